// File: rtl/spi_boot_sequencer_if.sv
// Bus bundle between the boot sequencer, the SPI register block, the CPU window and boot RAM.
// Signal names are from the sequencer's point of view (master modport).
interface spi_boot_sequencer_if;
  logic [1:0]  o_spiAddr;
  logic [15:0] o_spiWrData;
  logic        o_spiWrEn;
  logic [15:0] i_spiRdData;
  logic [1:0]  i_cpuAddr;
  logic [15:0] i_cpuWrData;
  logic        i_cpuWrEn;
  logic [15:0] o_cpuRdData;
  logic [15:0] o_ramAddr;
  logic [15:0] o_ramData;
  logic        o_ramWrEn;

  modport master (
    output o_spiAddr, o_spiWrData, o_spiWrEn, o_cpuRdData,
    output o_ramAddr, o_ramData, o_ramWrEn,
    input  i_spiRdData, i_cpuAddr, i_cpuWrData, i_cpuWrEn
  );

  modport slave (
    input  o_spiAddr, o_spiWrData, o_spiWrEn, o_cpuRdData,
    input  o_ramAddr, o_ramData, o_ramWrEn,
    output i_spiRdData, i_cpuAddr, i_cpuWrData, i_cpuWrEn
  );
endinterface

// File: rtl/spi_boot_sequencer.sv
// Boot-time owner of the SPI window: unlocks, streams WORD_COUNT words from flash to RAM, relocks.
// Optional SPI_BOOT_CKSUM_EN: last word must equal the 16-bit wrap sum of all earlier words.
module spi_boot_sequencer #(
  parameter int unsigned WORD_COUNT = 256,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter logic [15:0] RAM_BASE   = 16'h0000,
  parameter int unsigned POLL_LIMIT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_boot_sequencer_if.master bus,
  output logic                 o_bootDone,
  output logic                 o_bootErr
);

  typedef enum logic [3:0] {
    S_UNLOCK, S_CHK, S_WR, S_GAP, S_POLL, S_CAP, S_RAMWR, S_RELOCK, S_DONE, S_ERR, S_HALT
  } state_t;

  typedef enum logic [2:0] {B_CMD, B_A2, B_A1, B_A0, B_HI, B_LO} byte_t;

  state_t      r_state, w_state;
  byte_t       r_byte, w_byte;
  logic        r_armed;
  logic [15:0] r_poll, w_poll, w_pollInc;
  logic [15:0] r_cnt, w_cnt;
  logic [7:0]  r_hi, w_hi, r_lo, w_lo, w_tx;
  logic        r_bootDone, w_bootDone, r_bootErr, w_bootErr;
  logic        w_last;
  logic [1:0]  w_spiAddr;
  logic [15:0] w_spiWrData, w_cpuRdData, w_ramAddr, w_ramData, w_rd;
  logic        w_spiWrEn, w_ramWrEn;
`ifdef SPI_BOOT_CKSUM_EN
  logic [15:0] r_sum, w_sum;
`endif

  assign w_rd      = bus.i_spiRdData;
  assign w_pollInc = r_poll + 16'd1;
  assign w_last    = (32'(r_cnt) + 32'd1) == WORD_COUNT;

  always_comb begin
    unique case (r_byte)
      B_CMD:   w_tx = 8'h03;
      B_A2:    w_tx = FLASH_ADDR[23:16];
      B_A1:    w_tx = FLASH_ADDR[15:8];
      B_A0:    w_tx = FLASH_ADDR[7:0];
      default: w_tx = 8'h00;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_byte      = r_byte;
    w_poll      = r_poll;
    w_cnt       = r_cnt;
    w_hi        = r_hi;
    w_lo        = r_lo;
    w_bootDone  = r_bootDone;
    w_bootErr   = r_bootErr;
    w_spiAddr   = '0;
    w_spiWrData = '0;
    w_spiWrEn   = 1'b0;
    w_cpuRdData = '0;
    w_ramAddr   = '0;
    w_ramData   = '0;
    w_ramWrEn   = 1'b0;
`ifdef SPI_BOOT_CKSUM_EN
    w_sum       = r_sum;
`endif
    case (r_state)
      // Unlock is held off one clock after reset so all outputs read zero while in reset.
      S_UNLOCK: if (r_armed) begin
        w_spiAddr   = 2'b01;
        w_spiWrData = 16'h2024;
        w_spiWrEn   = 1'b1;
        w_state     = S_CHK;
      end
      S_CHK: begin
        if (w_rd[14]) begin
          w_byte  = B_CMD;
          w_state = S_WR;
        end else begin
          w_bootErr = 1'b1;
          w_state   = S_ERR;
        end
      end
      S_WR: begin
        w_spiAddr   = 2'b10;
        w_spiWrData = {8'h00, w_tx};
        w_spiWrEn   = 1'b1;
        w_poll      = '0;
        w_state     = S_GAP;
      end
      S_GAP: begin
        w_spiAddr = 2'b10;
        w_state   = S_POLL;
      end
      S_POLL: begin
        w_poll = w_pollInc;
        if (w_rd[15]) begin
          w_poll = '0;
          unique case (r_byte)
            B_CMD:   begin w_byte = B_A2; w_state = S_WR; end
            B_A2:    begin w_byte = B_A1; w_state = S_WR; end
            B_A1:    begin w_byte = B_A0; w_state = S_WR; end
            B_A0:    begin w_byte = B_HI; w_state = S_WR; end
            default: w_state = S_CAP;
          endcase
        end else if (32'(w_pollInc) > POLL_LIMIT) begin
          w_bootErr = 1'b1;
          w_state   = S_ERR;
        end
      end
      S_CAP: begin
        w_spiAddr = 2'b10;
        if (r_byte == B_HI) begin
          w_hi    = w_rd[7:0];
          w_byte  = B_LO;
          w_state = S_WR;
        end else begin
          w_lo    = w_rd[7:0];
          w_state = S_RAMWR;
        end
      end
      S_RAMWR: begin
        w_ramWrEn = 1'b1;
        w_ramAddr = RAM_BASE + r_cnt;
        w_ramData = {r_hi, r_lo};
        w_cnt     = r_cnt + 16'd1;
        w_byte    = B_HI;
        w_state   = w_last ? S_RELOCK : S_WR;
`ifdef SPI_BOOT_CKSUM_EN
        w_sum = r_sum + {r_hi, r_lo};
        if (w_last && ({r_hi, r_lo} != r_sum)) begin
          w_bootErr = 1'b1;
          w_state   = S_ERR;
        end
`endif
      end
      S_RELOCK: begin
        w_spiAddr  = 2'b01;
        w_spiWrEn  = 1'b1;
        w_bootDone = 1'b1;
        w_state    = S_DONE;
      end
      S_DONE: begin
        w_spiAddr   = bus.i_cpuAddr;
        w_spiWrData = bus.i_cpuWrData;
        w_spiWrEn   = bus.i_cpuWrEn;
        w_cpuRdData = w_rd;
      end
      S_ERR: begin
        w_spiAddr = 2'b01;
        w_spiWrEn = 1'b1;
        w_state   = S_HALT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_UNLOCK;
      r_byte     <= B_HI;
      r_armed    <= 1'b0;
      r_poll     <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_bootDone <= 1'b0;
      r_bootErr  <= 1'b0;
`ifdef SPI_BOOT_CKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_byte     <= w_byte;
      r_armed    <= 1'b1;
      r_poll     <= w_poll;
      r_cnt      <= w_cnt;
      r_hi       <= w_hi;
      r_lo       <= w_lo;
      r_bootDone <= w_bootDone;
      r_bootErr  <= w_bootErr;
`ifdef SPI_BOOT_CKSUM_EN
      r_sum      <= w_sum;
`endif
    end
  end

  assign bus.o_spiAddr   = w_spiAddr;
  assign bus.o_spiWrData = w_spiWrData;
  assign bus.o_spiWrEn   = w_spiWrEn;
  assign bus.o_cpuRdData = w_cpuRdData;
  assign bus.o_ramAddr   = w_ramAddr;
  assign bus.o_ramData   = w_ramData;
  assign bus.o_ramWrEn   = w_ramWrEn;
  assign o_bootDone      = r_bootDone;
  assign o_bootErr       = r_bootErr;

endmodule

// File: tb/tb_spi_boot_sequencer.sv
// Directed bench for spi_boot_sequencer with a behavioural SPI/flash model and RAM write log.
module tb_spi_boot_sequencer;
  localparam int unsigned WC = 4;
  localparam logic [23:0] FA = 24'h010203;
  localparam logic [15:0] RB = 16'hFFFE;
  localparam int unsigned PL = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bootDone, bootErr;
  int   nChecks = 0;
  int   nFail = 0;

  spi_boot_sequencer_if bus();

  spi_boot_sequencer #(.WORD_COUNT(WC), .FLASH_ADDR(FA), .RAM_BASE(RB), .POLL_LIMIT(PL)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.master), .o_bootDone(bootDone), .o_bootErr(bootErr)
  );

  always #5 clk = ~clk;

  // SPI register block + flash model, and logs of what the DUT did
  logic [7:0]  flash [8];
  logic        lockBad, idleStuck;
  logic [15:0] m_lock;
  int          m_busy, m_nbytes;
  logic [7:0]  m_rx;
  logic [15:0] sent [4];
  logic [15:0] ramA [8];
  logic [15:0] ramD [8];
  int          nRam, nLockWr;
  logic [15:0] lastLock;
  logic        leak;

  always @(posedge clk) begin
    if (rst) begin
      m_lock <= '0; m_busy <= 0; m_nbytes <= 0; m_rx <= '0;
      nRam <= 0; nLockWr <= 0; lastLock <= 16'hFFFF; leak <= 1'b0;
      for (int i = 0; i < 4; i++) sent[i] <= 16'hFFFF;
    end else begin
      if (m_busy > 0) m_busy <= m_busy - 1;
      if (!bootDone && bus.o_cpuRdData != 16'h0000) leak <= 1'b1;
      if (bus.o_spiWrEn && bus.o_spiAddr == 2'b01) begin
        m_lock <= bus.o_spiWrData; nLockWr <= nLockWr + 1; lastLock <= bus.o_spiWrData;
      end
      if (bus.o_spiWrEn && bus.o_spiAddr == 2'b10) begin
        m_busy   <= 8;
        m_nbytes <= m_nbytes + 1;
        m_rx     <= (m_nbytes >= 4 && m_nbytes < 12) ? flash[m_nbytes-4] : 8'hFF;
        if (m_nbytes < 4) sent[m_nbytes] <= bus.o_spiWrData;
      end
      if (bus.o_ramWrEn) begin
        if (nRam < 8) begin ramA[nRam] <= bus.o_ramAddr; ramD[nRam] <= bus.o_ramData; end
        nRam <= nRam + 1;
      end
    end
  end

  always_comb begin
    case (bus.o_spiAddr)
      2'b00:   bus.i_spiRdData = {(!idleStuck && m_busy == 0), (!lockBad && m_lock == 16'h2024), 14'h0};
      2'b01:   bus.i_spiRdData = m_lock;
      2'b10:   bus.i_spiRdData = {8'h00, m_rx};
      default: bus.i_spiRdData = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bootDone || bootErr) begin hit = 1'b1; break; end
    end
  endtask

  bit hit;
  int polls;
  bit seenW;

  initial begin
    flash = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02};
    lockBad = 1'b0; idleStuck = 1'b0;
    bus.i_cpuAddr = 2'b01; bus.i_cpuWrData = 16'h2024; bus.i_cpuWrEn = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_spi", {13'h0, bus.o_spiAddr, bus.o_spiWrEn, bus.o_spiWrData}, 32'h0);
    check("rst_ram", {bus.o_ramWrEn, bus.o_ramAddr}, 32'h0);
    check("rst_flags", {bootDone, bootErr, bus.o_cpuRdData}, 32'h0);
    rst = 1'b0;

    // Full copy with CPU hammering the lock register throughout
    wait_end(3000, hit);
    check("copy_timeout", hit, 1);
    check("copy_done", {bootDone, bootErr}, 32'h2);
    check("copy_nram", nRam, 4);
    check("ram_a0", ramA[0], 16'hFFFE);
    check("ram_a1", ramA[1], 16'hFFFF);
    check("ram_a2_wrap", ramA[2], 16'h0000);
    check("ram_a3", ramA[3], 16'h0001);
    check("ram_d0", ramD[0], 16'h1234);
    check("ram_d1", ramD[1], 16'hABCD);
    check("ram_d2", ramD[2], 16'h0001);
    check("ram_d3", ramD[3], 16'hBE02);
    check("cmd_bytes", {sent[0][7:0], sent[1][7:0], sent[2][7:0], sent[3][7:0]}, 32'h03010203);
    check("lock_wr_cnt", nLockWr, 2);
    check("lock_relock", lastLock, 16'h0000);
    check("cpu_rd_blocked", leak, 0);

    // Pass-through once released
    check("done_fwd", {bus.o_spiAddr, bus.o_spiWrEn, bus.o_spiWrData}, {2'b01, 1'b1, 16'h2024});
    bus.i_cpuWrEn = 1'b0; bus.i_cpuAddr = 2'b00;
    #1 check("done_rd_status", bus.o_cpuRdData, 16'h8000);
    @(negedge clk);
    bus.i_cpuWrEn = 1'b1; bus.i_cpuAddr = 2'b01;
    @(negedge clk);
    bus.i_cpuWrEn = 1'b0; bus.i_cpuAddr = 2'b00;
    #1 check("done_rd_unlocked", bus.o_cpuRdData, 16'hC000);

    // Async reset in the middle of word 3, then a clean recopy
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (nRam == 2 && bus.o_spiWrEn && bus.o_spiAddr == 2'b10) begin hit = 1'b1; break; end
    end
    check("mid_word3_timeout", hit, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_out", {bus.o_spiAddr, bus.o_spiWrEn, bus.o_spiWrData, bus.o_ramWrEn}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_end(3000, hit);
    check("recopy_timeout", hit, 1);
    check("recopy_done", {bootDone, bootErr}, 32'h2);
    check("recopy_nram", nRam, 4);
    check("recopy_a0", ramA[0], 16'hFFFE);
    check("recopy_d3", ramD[3], 16'hBE02);

    // Last word not equal to the running sum of the others
    flash[7] = 8'h03;
    do_reset();
    wait_end(3000, hit);
    check("sum_timeout", hit, 1);
    check("sum_nram", nRam, 4);
    check("sum_d3", ramD[3], 16'hBE03);
`ifdef SPI_BOOT_CKSUM_EN
    check("sum_flags", {bootDone, bootErr}, 32'h1);
    @(negedge clk);
    check("sum_err_relock", {nLockWr, lastLock}, {32'd2, 16'h0000});
`else
    check("sum_flags", {bootDone, bootErr}, 32'h2);
`endif
    flash[7] = 8'h02;

    // Lock check fails
    lockBad = 1'b1;
    do_reset();
    bus.i_cpuWrEn = 1'b1; bus.i_cpuAddr = 2'b01;
    wait_end(200, hit);
    check("lock_timeout", hit, 1);
    check("lock_flags", {bootDone, bootErr}, 32'h1);
    repeat (5) @(negedge clk);
    check("lock_nram", nRam, 0);
    check("lock_err_writes", nLockWr, 2);
    check("lock_err_val", lastLock, 16'h0000);
    check("lock_cpu_blocked", {bus.o_spiWrEn, bus.o_cpuRdData}, 32'h0);
    bus.i_cpuWrEn = 1'b0; bus.i_cpuAddr = 2'b00;
    lockBad = 1'b0;

    // SPI idle flag never returns
    idleStuck = 1'b1;
    do_reset();
    polls = 0; seenW = 1'b0; hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bootErr) begin hit = 1'b1; break; end
      if (seenW && bus.o_spiAddr == 2'b00 && !bus.o_spiWrEn) polls++;
      if (bus.o_spiWrEn && bus.o_spiAddr == 2'b10) seenW = 1'b1;
    end
    check("stuck_timeout", hit, 1);
    check("stuck_polls", polls, PL + 1);
    check("stuck_flags", {bootDone, bootErr}, 32'h1);
    check("stuck_nram", nRam, 0);
    idleStuck = 1'b0;

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end
endmodule
